// File: rtl/d_axi_bridge_if.sv
// AXI3/AXI4-lite-style single-beat bus between the d_cache bridge and memory.
// The bridge uses the master modport; the memory side (or a bench) uses slave.
interface d_axi_bridge_if;
  // AR channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  // R channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AW channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  // W channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // B channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/d_axi_bridge.sv
// d_cache miss/writeback port to AXI bridge. One single-beat transaction in
// flight at a time: reads go AR -> R, writes go AW+W (in any order) -> B.
module d_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_data_req,
  input  logic        cache_data_wr,
  input  logic [1:0]  cache_data_size,
  input  logic [31:0] cache_data_addr,
  input  logic [31:0] cache_data_wdata,
  output logic [31:0] cache_data_rdata,
  output logic        cache_data_addr_ok,
  output logic        cache_data_data_ok,
  d_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE,
    RA,
    RD,
    WAW,
    WB
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        aw_done_q;
  logic        w_done_q;

  logic        ar_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_fin;
  logic        w_fin;
  logic [2:0]  axsize;
  logic [3:0]  strb;
  logic        unused_inputs;

  // Handshake and completion terms used by the FSM
  always_comb begin
    ar_hs  = arvalid_q & axi.arready;
    aw_hs  = awvalid_q & axi.awready;
    w_hs   = wvalid_q & axi.wready;
    // a channel counts as finished in the cycle of its handshake, so both
    // finishing together still moves to WB in one step
    aw_fin = aw_done_q | aw_hs;
    w_fin  = w_done_q | w_hs;
  end

  // Transaction FSM with registered channel valids/readies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cache_data_req) begin
            addr_q  <= cache_data_addr;
            wdata_q <= cache_data_wdata;
            wr_q    <= cache_data_wr;
            size_q  <= cache_data_size;
            if (cache_data_wr) begin
              state_q   <= WAW;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RA;
              arvalid_q <= 1'b1;
            end
          end
        end
        RA: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD;
          end
        end
        RD: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        WAW: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= WB;
          end
        end
        WB: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // AXI size code and write strobe from the captured size/address
  always_comb begin
    axsize = 3'b010;
    strb   = 4'b1111;
    case (size_q)
      2'd0: begin
        axsize = 3'b000;
        strb   = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        axsize = 3'b001;
        strb   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        axsize = 3'b010;
        strb   = 4'b1111;
      end
    endcase
  end

  // Upstream handshake: accept only in IDLE and never while reset is held
  always_comb begin
    cache_data_addr_ok = rst & (state_q == IDLE) & cache_data_req;
    cache_data_data_ok = ((state_q == RD) & axi.rvalid) |
                         ((state_q == WB) & axi.bvalid);
    cache_data_rdata   = axi.rdata;
  end

  // Response ids/status and the captured direction carry no information here
  assign unused_inputs = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp, wr_q};

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = '0;
  assign axi.arsize  = axsize;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = '0;
  assign axi.awsize  = axsize;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;

  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = strb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;

  assign axi.bready  = bready_q;

endmodule

// File: tb/tb_d_axi_bridge.sv
// Scoreboard bench for d_axi_bridge: stimulus pushes expected transactions,
// a negedge monitor pops them on addr_ok and checks every AXI beat and data_ok.
module tb_d_axi_bridge;

  localparam logic [3:0] TB_ID = 4'd5;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          d_a;
    int          d_w;
    int          d_b;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata;
  logic        cache_data_addr_ok;
  logic        cache_data_data_ok;

  d_axi_bridge_if bus ();

  d_axi_bridge #(.AXI_ID(TB_ID)) dut (
    .clk                (clk),
    .rst                (rst),
    .cache_data_req     (cache_data_req),
    .cache_data_wr      (cache_data_wr),
    .cache_data_size    (cache_data_size),
    .cache_data_addr    (cache_data_addr),
    .cache_data_wdata   (cache_data_wdata),
    .cache_data_rdata   (cache_data_rdata),
    .cache_data_addr_ok (cache_data_addr_ok),
    .cache_data_data_ok (cache_data_data_ok),
    .axi                (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference rules: bytes touched and the naturally aligned lane they occupy
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_size(input logic [1:0] s);
    return 32'($clog2(nbytes(s)));
  endfunction

  function automatic logic [31:0] exp_strb(input logic [1:0] s, input logic [31:0] a);
    int nb = nbytes(s);
    int lo = (int'(a % 4) / nb) * nb;
    return 32'(((1 << nb) - 1) << lo);
  endfunction

  // ---------------- monitor ----------------
  bit          busy = 0;
  txn_t        cur;
  int          ar_cnt, aw_cnt, w_cnt;
  bit          prev_ar, prev_aw, prev_w;
  logic [31:0] prev_araddr, prev_awaddr, prev_wdata;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_arvalid", bus.arvalid, 0);
      check("rst_awvalid", bus.awvalid, 0);
      check("rst_wvalid", bus.wvalid, 0);
      check("rst_rready", bus.rready, 0);
      check("rst_bready", bus.bready, 0);
      check("rst_addr_ok", cache_data_addr_ok, 0);
      check("rst_data_ok", cache_data_data_ok, 0);
      busy    = 0;
      prev_ar = 0;
      prev_aw = 0;
      prev_w  = 0;
    end else begin
      check("ok_overlap", cache_data_addr_ok & cache_data_data_ok, 0);
      if (prev_ar) begin
        check("ar_hold", bus.arvalid, 1);
        check("ar_stable", bus.araddr, prev_araddr);
      end
      if (prev_aw) begin
        check("aw_hold", bus.awvalid, 1);
        check("aw_stable", bus.awaddr, prev_awaddr);
      end
      if (prev_w) begin
        check("w_hold", bus.wvalid, 1);
        check("w_stable", bus.wdata, prev_wdata);
      end
      if (busy) begin
        if (!cur.wr) begin
          check("rd_no_aw_w", bus.awvalid | bus.wvalid, 0);
          if (ar_cnt == 1) begin
            check("arvalid_drop", bus.arvalid, 0);
            check("rready", bus.rready, 1);
          end
          if (bus.arvalid && bus.arready) begin
            check("araddr", bus.araddr, cur.addr);
            check("arsize", bus.arsize, exp_size(cur.size));
            check("arlen_burst", {bus.arlen, bus.arburst}, {8'd0, 2'b01});
            check("arid", bus.arid, TB_ID);
            ar_cnt++;
          end
          if (cache_data_data_ok) begin
            check("rdata", cache_data_rdata, cur.rdata);
            check("ar_beats", ar_cnt, 1);
            busy = 0;
          end
        end else begin
          check("wr_no_ar", bus.arvalid, 0);
          if (aw_cnt == 1) check("awvalid_drop", bus.awvalid, 0);
          if (w_cnt == 1) check("wvalid_drop", bus.wvalid, 0);
          if (aw_cnt == 1 && w_cnt == 1) check("bready", bus.bready, 1);
          if (bus.awvalid && bus.awready) begin
            check("awaddr", bus.awaddr, cur.addr);
            check("awsize", bus.awsize, exp_size(cur.size));
            check("awlen_burst", {bus.awlen, bus.awburst}, {8'd0, 2'b01});
            check("awid", bus.awid, TB_ID);
            aw_cnt++;
          end
          if (bus.wvalid && bus.wready) begin
            check("wdata", bus.wdata, cur.wdata);
            check("wstrb", bus.wstrb, exp_strb(cur.size, cur.addr));
            check("wlast_wid", {bus.wlast, bus.wid}, {1'b1, TB_ID});
            w_cnt++;
          end
          if (cache_data_data_ok) begin
            check("aw_beats", aw_cnt, 1);
            check("w_beats", w_cnt, 1);
            busy = 0;
          end
        end
      end else begin
        check("idle_data_ok", cache_data_data_ok, 0);
        check("idle_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 0);
      end
      if (cache_data_addr_ok) begin
        check("addr_ok_outstanding", busy, 0);
        if (exp_q.size() == 0) begin
          check("addr_ok_unexpected", 1, 0);
        end else begin
          cur    = exp_q.pop_front();
          busy   = 1;
          ar_cnt = 0;
          aw_cnt = 0;
          w_cnt  = 0;
        end
      end
      prev_ar     = bus.arvalid & ~bus.arready;
      prev_aw     = bus.awvalid & ~bus.awready;
      prev_w      = bus.wvalid & ~bus.wready;
      prev_araddr = bus.araddr;
      prev_awaddr = bus.awaddr;
      prev_wdata  = bus.wdata;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cond(input int sel, input string name);
    bit hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      case (sel)
        0:       hit = bus.arvalid;
        1:       hit = bus.rready;
        2:       hit = bus.awvalid;
        3:       hit = bus.wvalid;
        4:       hit = bus.bready;
        default: hit = cache_data_addr_ok;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: no event within 40 cycles, expected one", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [1:0] resp, input int d_a, input int d_w, input int d_b);
    txn_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata; t.rdata = rdata;
    t.resp = resp; t.d_a = d_a; t.d_w = d_w; t.d_b = d_b;
    return t;
  endfunction

  task automatic run_txn(input txn_t t, input bit keep_req);
    cache_data_req   = 1'b1;
    cache_data_wr    = t.wr;
    cache_data_addr  = t.addr;
    cache_data_size  = t.size;
    cache_data_wdata = t.wdata;
    exp_q.push_back(t);
    wait_cond(5, "addr_ok");
    // upstream is scrambled after capture; the bridge must not follow it
    cache_data_req   = keep_req;
    cache_data_wr    = 1'($urandom);
    cache_data_addr  = $urandom;
    cache_data_size  = 2'($urandom);
    cache_data_wdata = $urandom;
    if (!t.wr) begin
      idle(t.d_a);
      bus.arready = 1'b1;
      wait_cond(0, "ar");
      bus.arready = 1'b0;
      idle(t.d_b);
      bus.rvalid = 1'b1;
      bus.rdata  = t.rdata;
      bus.rresp  = t.resp;
      bus.rlast  = 1'($urandom);
      bus.rid    = 4'($urandom);
      wait_cond(1, "r");
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
    end else begin
      fork
        begin
          idle(t.d_a);
          bus.awready = 1'b1;
          wait_cond(2, "aw");
          bus.awready = 1'b0;
        end
        begin
          idle(t.d_w);
          bus.wready = 1'b1;
          wait_cond(3, "w");
          bus.wready = 1'b0;
        end
      join
      idle(t.d_b);
      bus.bvalid = 1'b1;
      bus.bresp  = t.resp;
      bus.bid    = 4'($urandom);
      wait_cond(4, "b");
      bus.bvalid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    cache_data_req = 1'b0; cache_data_wr = 1'b0; cache_data_size = '0;
    cache_data_addr = '0; cache_data_wdata = '0;
    bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rid = '0;
    bus.bvalid = 1'b0; bus.bresp = '0; bus.bid = '0;
    idle(3);
    rst = 1'b1;
    idle(1);

    // word read, AR accepted after 3 cycles, data 2 cycles later
    run_txn(mk(0, 32'h1FC0_0010, 2'd2, 32'h0, 32'hDEAD_BEEF, 2'b00, 3, 0, 2), 0);
    idle(1);
    // byte write to lane 3, W accepted two cycles before AW
    run_txn(mk(1, 32'h8000_0003, 2'd0, 32'h0000_00AB, 32'h0, 2'b00, 2, 0, 1), 0);
    idle(1);
    // AW and W both accepted on the first WAW cycle
    run_txn(mk(1, 32'h0000_1006, 2'd1, 32'h1234_5678, 32'h0, 2'b00, 0, 0, 0), 0);
    // two reads with req held high throughout
    run_txn(mk(0, 32'h0000_2000, 2'd3, 32'h0, 32'hCAFE_0001, 2'b00, 0, 0, 0), 1);
    run_txn(mk(0, 32'h0000_2005, 2'd0, 32'h0, 32'hCAFE_0002, 2'b00, 1, 0, 1), 0);
    idle(2);

    // reset while AW/W are still pending; the aborted write must not complete
    cache_data_req = 1'b1; cache_data_wr = 1'b1; cache_data_addr = 32'h0000_3000;
    cache_data_size = 2'd2; cache_data_wdata = 32'h5555_AAAA;
    exp_q.push_back(mk(1, 32'h0000_3000, 2'd2, 32'h5555_AAAA, 32'h0, 2'b00, 0, 0, 0));
    wait_cond(5, "addr_ok_abort");
    cache_data_req = 1'b0;
    idle(1);
    rst = 1'b0;
    cache_data_req = 1'b1;
    idle(2);
    cache_data_req = 1'b0;
    #2;
    rst = 1'b1;
    idle(1);
    run_txn(mk(0, 32'h0000_3010, 2'd2, 32'h0, 32'h0BAD_F00D, 2'b00, 1, 0, 1), 0);

    // error responses still complete and the next request is taken
    run_txn(mk(1, 32'h0000_4002, 2'd1, 32'hFFFF_0000, 32'h0, 2'b10, 1, 1, 2), 0);
    run_txn(mk(0, 32'h0000_4004, 2'd2, 32'h0, 32'h7777_8888, 2'b11, 0, 0, 0), 0);

    for (int i = 0; i < 40; i++) begin
      bit keep = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn(mk(1'($urandom_range(0, 1)), $urandom, 2'($urandom), $urandom, $urandom,
                 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3)), keep);
      if (!keep) idle($urandom_range(0, 2));
    end

    idle(3);
    check("queue_drained", exp_q.size(), 0);
    check("nothing_outstanding", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
